path_readback_controller: RTL and testbench

- Read-side counterpart of the start/end-point loader for the RISC-V path-planning core.
- After the CPU runs, the block polls the mailbox done flag at 0x0200000C and reads the node count at 0x02000008.
- It then fetches each path node from 0x02000010 + 4*i over the external data-memory read port.
- Nodes are streamed to the motion/display logic over a valid/ready handshake.

---
 rtl/path_readback_controller.sv | 197 +++++++++++++++++++
 tb/tb_path_readback_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_readback_controller.sv
// Reads the path-planner mailbox after a CPU run: polls the done flag, latches the
// node count, then streams each node word to the consumer over a valid/ready handshake.
module path_readback_controller #(
    parameter int          MAX_NODES      = 32,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [31:0] BASE_ADR       = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] Ext_ReadAdr,
    input  logic [31:0] Ext_ReadData,
    output logic [4:0]  node,
    output logic        node_valid,
    input  logic        node_ready,
    output logic        node_last,
    output logic [5:0]  path_len,
    output logic        busy,
    output logic        path_done,
    output logic        error
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAX_W    = 32'(MAX_NODES);
    localparam logic [31:0] DONE_ADR = BASE_ADR + 32'h0000_000C;
    localparam logic [31:0] CNT_ADR  = BASE_ADR + 32'h0000_0008;
    localparam logic [31:0] NODE_ADR = BASE_ADR + 32'h0000_0010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POLL  = 3'd1,
        S_LEN   = 3'd2,
        S_FETCH = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    adr_q, adr_d;
    logic [4:0]     node_q, node_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic [5:0]     len_q, len_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [4:0]     idx_q, idx_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [5:0]     idx_inc_s;
    logic           xfer_s;

    assign idx_inc_s = {1'b0, idx_q} + 6'd1;
    assign xfer_s    = valid_q && node_ready;

    // Next-state and registered-output computation for the readback sequence.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        node_d  = node_q;
        valid_d = valid_q;
        last_d  = last_q;
        len_d   = len_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    tcnt_d  = '0;
                    adr_d   = DONE_ADR;
                    state_d = S_POLL;
                end else begin
                    adr_d   = 32'd0;
                end
            end

            S_POLL: begin
                if (Ext_ReadData[0]) begin
                    adr_d   = CNT_ADR;
                    tcnt_d  = '0;
                    state_d = S_LEN;
                end else if (tcnt_q == T_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    tcnt_d  = '0;
                    adr_d   = 32'd0;
                    state_d = S_ERR;
                end else begin
                    tcnt_d  = tcnt_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end

            S_LEN: begin
                if (Ext_ReadData > MAX_W) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    len_d   = 6'd0;
                    adr_d   = 32'd0;
                    state_d = S_ERR;
                end else if (Ext_ReadData == 32'd0) begin
                    len_d   = 6'd0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    adr_d   = 32'd0;
                    state_d = S_DONE;
                end else begin
                    len_d   = Ext_ReadData[5:0];
                    idx_d   = 5'd0;
                    adr_d   = NODE_ADR;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                node_d  = Ext_ReadData[4:0];
                valid_d = 1'b1;
                last_d  = ({1'b0, idx_q} == (len_q - 6'd1));
                state_d = S_EMIT;
            end

            // Outputs stay frozen until the consumer takes the node.
            S_EMIT: begin
                if (xfer_s) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        adr_d   = 32'd0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_inc_s[4:0];
                        adr_d   = NODE_ADR + {24'd0, idx_inc_s, 2'b00};
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end

            default: begin
                state_d = S_IDLE;
                adr_d   = 32'd0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            adr_q   <= 32'd0;
            node_q  <= 5'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            len_q   <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= 5'd0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            node_q  <= node_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign Ext_ReadAdr = adr_q;
    assign node        = node_q;
    assign node_valid  = valid_q;
    assign node_last   = last_q;
    assign path_len    = len_q;
    assign busy        = busy_q;
    assign path_done   = done_q;
    assign error       = err_q;

endmodule

// File: tb/tb_path_readback_controller.sv
// Bench for path_readback_controller: a mailbox memory model, a table of readback
// scenarios, hand-written handshake/reset sequences and randomized runs.
module tb_path_readback_controller;

    localparam int          T        = 16;
    localparam int          MAXN     = 32;
    localparam logic [31:0] BASE     = 32'h0200_0000;
    localparam logic [31:0] DONE_ADR = 32'h0200_000C;
    localparam logic [31:0] CNT_ADR  = 32'h0200_0008;
    localparam logic [31:0] NODE_ADR = 32'h0200_0010;

    logic        clk = 1'b0;
    logic        reset, start, node_ready;
    logic [31:0] Ext_ReadAdr, Ext_ReadData;
    logic [4:0]  node;
    logic        node_valid, node_last, busy, path_done, error;
    logic [5:0]  path_len;

    path_readback_controller #(
        .MAX_NODES(MAXN), .TIMEOUT_CYCLES(T), .BASE_ADR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .Ext_ReadAdr(Ext_ReadAdr), .Ext_ReadData(Ext_ReadData),
        .node(node), .node_valid(node_valid), .node_ready(node_ready),
        .node_last(node_last), .path_len(path_len), .busy(busy),
        .path_done(path_done), .error(error)
    );

    always #5 clk = ~clk;

    // Mailbox memory model
    logic [31:0] mem [32];
    logic [31:0] cnt_word;
    logic [31:0] off_s;
    int          done_delay;
    int          poll_cnt;
    bit          poll_clr;

    always_comb begin
        off_s = Ext_ReadAdr - NODE_ADR;
        Ext_ReadData = 32'hDEAD_BEEF;
        if (Ext_ReadAdr == DONE_ADR)
            Ext_ReadData = {31'h2A5A_5A5A, (poll_cnt >= done_delay)};
        else if (Ext_ReadAdr == CNT_ADR)
            Ext_ReadData = cnt_word;
        else if (Ext_ReadAdr >= NODE_ADR && off_s < 32'd128)
            Ext_ReadData = mem[off_s[6:2]];
    end

    always @(posedge clk) begin
        if (poll_clr) poll_cnt <= 0;
        else if (Ext_ReadAdr == DONE_ADR) poll_cnt <= poll_cnt + 1;
    end

    int tests = 0;
    int fails = 0;
    int exp_len_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_start();
        start = 1'b1; poll_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; poll_clr = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_err_clr", {31'd0, error}, 32'd0);
        check("start_done_clr", {31'd0, path_done}, 32'd0);
        check("start_adr", Ext_ReadAdr, DONE_ADR);
    endtask

    // One readback, checked against the mailbox contents and the readback rules.
    task automatic run_case(input int d, input logic [31:0] cnt, input bit rnd);
        logic [4:0] got_n[$];
        bit         got_l[$];
        int  cyc, n, lat, polls;
        bit  e_err, e_done, pv, pr;
        logic [4:0] pn;
        bit  pl;
        done_delay = d;
        cnt_word   = cnt;
        node_ready = 1'b1;
        check_start();
        cyc = 0; pv = 0; pr = 0; pn = 5'd0; pl = 0;
        while (busy && cyc < 3000) begin
            if (rnd) begin
                node_ready = ($urandom_range(0, 3) != 0);
                start      = ($urandom_range(0, 7) == 0);
            end else begin
                node_ready = 1'b1;
            end
            if (pv && !pr) begin
                check("hold_valid", {31'd0, node_valid}, 32'd1);
                check("hold_node", {27'd0, node}, {27'd0, pn});
                check("hold_last", {31'd0, node_last}, {31'd0, pl});
            end
            if (node_valid && node_ready) begin
                got_n.push_back(node);
                got_l.push_back(node_last);
            end
            pv = node_valid; pr = node_ready; pn = node; pl = node_last;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (busy) begin
            fails++; tests++;
            $display("FAIL run_timeout: got busy after %0d cycles expected idle", cyc);
        end

        polls = (d >= T) ? T : d + 1;
        if (d >= T) begin
            e_err = 1; e_done = 0; n = 0; lat = T;
        end else if (cnt > 32'(MAXN)) begin
            e_err = 1; e_done = 0; n = 0; lat = polls + 1; exp_len_m = 0;
        end else begin
            e_err = 0; e_done = 1; n = int'(cnt); lat = polls + 1 + 2 * n; exp_len_m = n;
        end

        check("node_count", got_n.size(), n);
        for (int i = 0; i < n && i < got_n.size(); i++) begin
            check($sformatf("node[%0d]", i), {27'd0, got_n[i]}, {27'd0, mem[i][4:0]});
            check($sformatf("last[%0d]", i), {31'd0, got_l[i]}, {31'd0, (i == n - 1)});
        end
        check("error", {31'd0, error}, {31'd0, e_err});
        check("path_done", {31'd0, path_done}, {31'd0, e_done});
        check("path_len", {26'd0, path_len}, 32'(exp_len_m));
        check("end_adr", Ext_ReadAdr, 32'd0);
        check("end_valid", {31'd0, node_valid}, 32'd0);
        if (!rnd) check("latency", cyc, lat);
    endtask

    typedef struct {
        int          d;
        logic [31:0] cnt;
        logic [31:0] n0, n1, n2;
        bit          e_err;
        bit          e_done;
        logic [5:0]  e_len;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{0,  32'd3,  32'h0000_0004, 32'hABCD_0009, 32'h0000_0011, 1'b0, 1'b1, 6'd3};
        tbl[1]  = '{10, 32'd1,  32'hFFFF_FFF6, 32'h0, 32'h0, 1'b0, 1'b1, 6'd1};
        tbl[2]  = '{20, 32'd5,  32'h1, 32'h2, 32'h3, 1'b1, 1'b0, 6'd1};
        tbl[3]  = '{0,  32'd2,  32'h7, 32'h1F, 32'h3, 1'b0, 1'b1, 6'd2};
        tbl[4]  = '{15, 32'd1,  32'h5, 32'h0, 32'h0, 1'b0, 1'b1, 6'd1};
        tbl[5]  = '{16, 32'd1,  32'h5, 32'h0, 32'h0, 1'b1, 1'b0, 6'd1};
        tbl[6]  = '{0,  32'd0,  32'h5, 32'h0, 32'h0, 1'b0, 1'b1, 6'd0};
        tbl[7]  = '{0,  32'd33, 32'h5, 32'h0, 32'h0, 1'b1, 1'b0, 6'd0};
        tbl[8]  = '{0,  32'd32, 32'h8, 32'h9, 32'hA, 1'b0, 1'b1, 6'd32};
        tbl[9]  = '{3,  32'h40, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 6'd0};
        tbl[10] = '{0,  32'd1,  32'h13, 32'h0, 32'h0, 1'b0, 1'b1, 6'd1};

        reset = 1'b1; start = 1'b0; node_ready = 1'b0; poll_clr = 1'b1;
        done_delay = 0; cnt_word = 32'd0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; poll_clr = 1'b0;
        check("rst_adr", Ext_ReadAdr, 32'd0);
        check("rst_node", {27'd0, node}, 32'd0);
        check("rst_valid", {31'd0, node_valid}, 32'd0);
        check("rst_last", {31'd0, node_last}, 32'd0);
        check("rst_len", {26'd0, path_len}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, path_done}, 32'd0);
        check("rst_err", {31'd0, error}, 32'd0);

        for (int v = 0; v < 11; v++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            mem[0] = tbl[v].n0; mem[1] = tbl[v].n1; mem[2] = tbl[v].n2;
            run_case(tbl[v].d, tbl[v].cnt, 1'b0);
            check($sformatf("tbl%0d_err", v), {31'd0, error}, {31'd0, tbl[v].e_err});
            check($sformatf("tbl%0d_done", v), {31'd0, path_done}, {31'd0, tbl[v].e_done});
            check($sformatf("tbl%0d_len", v), {26'd0, path_len}, {26'd0, tbl[v].e_len});
        end

        // Consumer stalls for 5 cycles on the second node.
        begin
            int k;
            mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3;
            done_delay = 0; cnt_word = 32'd3; node_ready = 1'b1;
            check_start();
            k = 0;
            while (!(node_valid && node == 5'd2) && k < 50) begin
                @(posedge clk); @(negedge clk); k++;
            end
            node_ready = 1'b0;
            check("stall_reach", {31'd0, (k < 50)}, 32'd1);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); @(negedge clk);
                check("stall_valid", {31'd0, node_valid}, 32'd1);
                check("stall_node", {27'd0, node}, 32'd2);
                check("stall_last", {31'd0, node_last}, 32'd0);
                check("stall_adr", Ext_ReadAdr, NODE_ADR + 32'd4);
            end
            node_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            check("post_xfer_adr", Ext_ReadAdr, NODE_ADR + 32'd8);
            check("post_xfer_valid", {31'd0, node_valid}, 32'd0);
            @(posedge clk); @(negedge clk);
            check("third_node", {27'd0, node}, 32'd3);
            check("third_last", {31'd0, node_last}, 32'd1);
            @(posedge clk); @(negedge clk);
            check("stall_done", {31'd0, path_done}, 32'd1);
            check("stall_busy", {31'd0, busy}, 32'd0);
            exp_len_m = 3;
        end

        // Reset while a node is waiting for the consumer.
        begin
            int k;
            done_delay = 0; cnt_word = 32'd3; node_ready = 1'b0;
            check_start();
            k = 0;
            while (!node_valid && k < 50) begin
                @(posedge clk); @(negedge clk); k++;
            end
            check("emit_reach", {31'd0, node_valid}, 32'd1);
            reset = 1'b1;
            @(posedge clk); @(negedge clk);
            reset = 1'b0;
            check("mid_rst_adr", Ext_ReadAdr, 32'd0);
            check("mid_rst_node", {27'd0, node}, 32'd0);
            check("mid_rst_valid", {31'd0, node_valid}, 32'd0);
            check("mid_rst_last", {31'd0, node_last}, 32'd0);
            check("mid_rst_len", {26'd0, path_len}, 32'd0);
            check("mid_rst_busy", {31'd0, busy}, 32'd0);
            check("mid_rst_done", {31'd0, path_done}, 32'd0);
            check("mid_rst_err", {31'd0, error}, 32'd0);
            node_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            check("idle_valid", {31'd0, node_valid}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            exp_len_m = 0;
        end

        // Randomized runs with random back-pressure and stray start pulses.
        for (int r = 0; r < 20; r++) begin
            int sel, d;
            logic [31:0] cnt;
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            sel = $urandom_range(0, 9);
            d   = $urandom_range(0, 18);
            if (sel == 0)      cnt = 32'd0;
            else if (sel == 1) cnt = 32'(33 + $urandom_range(0, 100));
            else if (sel == 2) cnt = $urandom;
            else               cnt = 32'($urandom_range(1, 32));
            run_case(d, cnt, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
